// File: rtl/alu_mul_sequencer_pkg.sv
// rtl/alu_mul_sequencer_pkg.sv - shared types and widths for the multiply request sequencer
package alu_pkg;

    localparam int MUL_LATENCY = 4;
    localparam int MUL_W       = 8;
    localparam int PROD_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mul_seq_state_t;

    // An operand of zero makes the product trivially zero.
    function automatic logic has_zero_operand(input logic [MUL_W-1:0] a, input logic [MUL_W-1:0] b);
        return (a == '0) || (b == '0);
    endfunction

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// rtl/alu_mul_sequencer_if.sv - request, multiplier and response signal bundle of the sequencer
interface alu_mul_sequencer_if
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic [MUL_W-1:0]     req_a;
    logic [MUL_W-1:0]     req_b;
    logic [TAG_W-1:0]     req_tag;

    logic                 mul_start;
    logic [MUL_W-1:0]     mul_a;
    logic [MUL_W-1:0]     mul_b;
    logic                 mul_done;
    logic [PROD_W-1:0]    mul_result;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [PROD_W-1:0]    rsp_result;
    logic [TAG_W-1:0]     rsp_tag;
    logic                 rsp_err;

    logic                 busy;

    // Sequencer side.
    modport slave (
        input  req_valid, req_a, req_b, req_tag,
        input  mul_done, mul_result,
        input  rsp_ready,
        output req_ready,
        output mul_start, mul_a, mul_b,
        output rsp_valid, rsp_result, rsp_tag, rsp_err,
        output busy
    );

    // Requester, multiplier and consumer side.
    modport master (
        output req_valid, req_a, req_b, req_tag,
        output mul_done, mul_result,
        output rsp_ready,
        input  req_ready,
        input  mul_start, mul_a, mul_b,
        input  rsp_valid, rsp_result, rsp_tag, rsp_err,
        input  busy
    );

endinterface

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - one-at-a-time multiply request sequencer with watchdog and zero bypass
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int TAG_W       = 4,
    parameter int TIMEOUT     = 8,
    parameter int ZERO_BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_mul_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mul_seq_state_t     state;
    mul_seq_state_t     state_nxt;

    logic [CNT_W-1:0]   wd_cnt;
    logic [MUL_W-1:0]   a_q;
    logic [MUL_W-1:0]   b_q;
    logic [TAG_W-1:0]   tag_q;
    logic [PROD_W-1:0]  result_q;
    logic               err_q;

    logic               req_ready_c;
    logic               mul_start_c;
    logic               rsp_valid_c;
    logic               busy_c;
    logic               bypass;
    logic               timeout_hit;

    assign bypass      = (ZERO_BYPASS != 0) && has_zero_operand(bus.req_a, bus.req_b);
    // Last permitted WAIT cycle: the counter started at 0 on the first one.
    assign timeout_hit = (wd_cnt == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/strobe decode.
    always_comb begin
        state_nxt   = state;
        req_ready_c = 1'b0;
        mul_start_c = 1'b0;
        rsp_valid_c = 1'b0;
        busy_c      = 1'b1;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                busy_c      = 1'b0;
                if (bus.req_valid) begin
                    state_nxt = bypass ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                mul_start_c = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (bus.mul_done || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, watchdog and response registers. Operands only move
    // on acceptance so the multiplier sees them stable for the whole operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        a_q      <= bus.req_a;
                        b_q      <= bus.req_b;
                        tag_q    <= bus.req_tag;
                        result_q <= '0;
                        err_q    <= 1'b0;
                        wd_cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (bus.mul_done) begin
                        result_q <= bus.mul_result;
                        err_q    <= 1'b0;
                    end else if (timeout_hit) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end else begin
                        wd_cnt   <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.mul_start  = mul_start_c;
    assign bus.mul_a      = a_q;
    assign bus.mul_b      = b_q;
    assign bus.rsp_valid  = rsp_valid_c;
    assign bus.rsp_result = result_q;
    assign bus.rsp_tag    = tag_q;
    assign bus.rsp_err    = err_q;
    assign bus.busy       = busy_c;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - randomized self-checking bench for the multiply request sequencer
module tb_alu_mul_sequencer;
    import alu_pkg::*;

    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_mul_sequencer_if #(.TAG_W(TAG_W)) bus ();

    alu_mul_sequencer #(
        .TAG_W(TAG_W),
        .TIMEOUT(TIMEOUT),
        .ZERO_BYPASS(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Multiplier stand-in: done arrives MUL_LATENCY cycles after the start
    // cycle, carrying the product of whatever sits on mul_a/mul_b then.
    logic [MUL_LATENCY-2:0] start_sr;
    logic                   model_done;
    logic [PROD_W-1:0]      model_result;
    logic                   suppress_done = 1'b0;
    logic                   force_done    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sr     <= '0;
            model_done   <= 1'b0;
            model_result <= '0;
        end else begin
            start_sr   <= {start_sr[MUL_LATENCY-3:0], bus.mul_start};
            model_done <= start_sr[MUL_LATENCY-2];
            if (start_sr[MUL_LATENCY-2]) begin
                model_result <= 16'(bus.mul_a) * 16'(bus.mul_b);
            end
        end
    end

    assign bus.mul_done   = (model_done & ~suppress_done) | force_done;
    assign bus.mul_result = model_result;

    // One request through to its handshake, checked against the arithmetic rules.
    task automatic xact(input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag,
                        input int hold, input bit exp_timeout);
        bit               zero_op;
        logic [15:0]      exp_res;
        int               exp_lat;
        int               n;
        int               starts;
        int               start_at;
        bit               seen;
        bit               stable;
        bit               rdy_leak;
        logic [20:0]      snap;
        zero_op  = (a == 8'd0) || (b == 8'd0);
        exp_res  = (exp_timeout || zero_op) ? 16'd0 : 16'(a) * 16'(b);
        exp_lat  = zero_op ? 1 : (exp_timeout ? 2 + TIMEOUT : 6);
        n = 0; starts = 0; start_at = 0; seen = 0; stable = 1; rdy_leak = 0;

        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_ready: got %b want 1", bus.req_ready);
        end
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        bus.req_valid = 1'b1;
        bus.rsp_ready = (hold == 0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;

        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.mul_start === 1'b1) begin
                starts++;
                start_at = n;
            end
            if (!zero_op && n <= 5 && (bus.mul_a !== a || bus.mul_b !== b)) stable = 0;
            if (bus.req_ready !== 1'b0) rdy_leak = 1;
            seen = (bus.rsp_valid === 1'b1);
        end

        vectors++;
        if (n != exp_lat || !seen) begin
            miscompares++;
            $display("FAIL latency a=%0d b=%0d: got %0d cycles want %0d", a, b, n, exp_lat);
        end
        vectors++;
        if (starts != (zero_op ? 0 : 1) || start_at != (zero_op ? 0 : 1)) begin
            miscompares++;
            $display("FAIL start_pulse a=%0d b=%0d: got %0d pulses at cycle %0d want %0d", a, b,
                     starts, start_at, zero_op ? 0 : 1);
        end
        vectors++;
        if (!stable || rdy_leak) begin
            miscompares++;
            $display("FAIL operand_hold a=%0d b=%0d: stable=%0d ready_leak=%0d want 1/0", a, b,
                     stable, rdy_leak);
        end
        snap = {bus.rsp_result, bus.rsp_tag, bus.rsp_err};
        vectors++;
        if (snap !== {exp_res, tag, exp_timeout}) begin
            miscompares++;
            $display("FAIL response a=%0d b=%0d: got res=%h tag=%h err=%b want res=%h tag=%h err=%b",
                     a, b, bus.rsp_result, bus.rsp_tag, bus.rsp_err, exp_res, tag, exp_timeout);
        end

        for (int i = 0; i < hold; i++) begin
            if (exp_timeout && i == 0) force_done = 1'b1;
            @(negedge clk);
            force_done = 1'b0;
            vectors++;
            if ({bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_tag, bus.rsp_err} !==
                {1'b1, 1'b0, snap}) begin
                miscompares++;
                $display("FAIL backpressure cycle %0d: got v=%b r=%b res=%h tag=%h err=%b want v=1 r=0 %h",
                         i, bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_tag, bus.rsp_err, snap);
            end
        end

        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL handshake: got v=%b r=%b want v=0 r=1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.req_ready, bus.mul_start, bus.rsp_valid, bus.rsp_err, bus.busy,
             bus.mul_a, bus.mul_b, bus.rsp_result, bus.rsp_tag} !== {1'b1, 4'b0, 36'h0}) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b st=%b v=%b err=%b busy=%b a=%h b=%h res=%h tag=%h want 1/0/0/0/0/0",
                     bus.req_ready, bus.mul_start, bus.rsp_valid, bus.rsp_err, bus.busy,
                     bus.mul_a, bus.mul_b, bus.rsp_result, bus.rsp_tag);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        xact(8'd13, 8'd11, 4'd3, 0, 0);
        xact(8'hFF, 8'hFF, 4'd5, 0, 0);
    endtask

    task automatic test_bypass();
        xact(8'h00, 8'h5A, 4'd9, 0, 0);
        xact(8'h77, 8'h00, 4'd1, 1, 0);
    endtask

    task automatic test_timeout();
        suppress_done = 1'b1;
        xact(8'd3, 8'd5, 4'd2, 3, 1);
        suppress_done = 1'b0;
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL late_done_idle: got busy=%b v=%b want 0/0", bus.busy, bus.rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        xact(8'd21, 8'd6, 4'd7, 5, 0);
    endtask

    task automatic test_back_to_back(input logic [7:0] a1, input logic [7:0] b1,
                                     input logic [7:0] a2, input logic [7:0] b2);
        int          n;
        bit          got;
        bit          r1_seen;
        int          exp_gap;
        logic [15:0] exp1;
        logic [15:0] exp2;
        exp_gap = ((a1 == 0) || (b1 == 0)) ? 2 : 7;
        exp1    = 16'(a1) * 16'(b1);
        exp2    = 16'(a2) * 16'(b2);
        n = 0; got = 0; r1_seen = 0;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.req_a = a1; bus.req_b = b1; bus.req_tag = 4'hA; bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_a = a2; bus.req_b = b2; bus.req_tag = 4'hB;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid === 1'b1 && !r1_seen) begin
                r1_seen = 1;
                vectors++;
                if ({bus.rsp_result, bus.rsp_tag, bus.rsp_err} !== {exp1, 4'hA, 1'b0}) begin
                    miscompares++;
                    $display("FAIL b2b_first: got res=%h tag=%h err=%b want %h/a/0",
                             bus.rsp_result, bus.rsp_tag, bus.rsp_err, exp1);
                end
            end
            got = (bus.req_ready === 1'b1);
        end
        vectors++;
        if (n != exp_gap || !r1_seen) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d cycles (rsp seen %0d) want %0d", n, r1_seen, exp_gap);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = (bus.rsp_valid === 1'b1);
        end
        vectors++;
        if (!got || {bus.rsp_result, bus.rsp_tag, bus.rsp_err} !== {exp2, 4'hB, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_second: got v=%b res=%h tag=%h err=%b want 1/%h/b/0",
                     got, bus.rsp_result, bus.rsp_tag, bus.rsp_err, exp2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit leaked;
        leaked = 0;
        @(negedge clk);
        bus.req_a = 8'd7; bus.req_b = 8'd9; bus.req_tag = 4'd4; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_busy: got %b want 1", bus.busy);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.req_ready, bus.mul_start, bus.rsp_valid, bus.rsp_err, bus.busy,
             bus.mul_a, bus.mul_b, bus.rsp_result, bus.rsp_tag} !== {1'b1, 4'b0, 36'h0}) begin
            miscompares++;
            $display("FAIL mid_reset: got rdy=%b st=%b v=%b err=%b busy=%b a=%h b=%h res=%h tag=%h want 1/0/0/0/0/0",
                     bus.req_ready, bus.mul_start, bus.rsp_valid, bus.rsp_err, bus.busy,
                     bus.mul_a, bus.mul_b, bus.rsp_result, bus.rsp_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) leaked = 1;
        end
        vectors++;
        if (leaked) begin
            miscompares++;
            $display("FAIL reset_abort: got a response after reset want none");
        end
        xact(8'd13, 8'd11, 4'd3, 0, 0);
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] b;
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            xact(a, b, 4'($urandom_range(0, 15)), $urandom_range(0, 2), 0);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_basic();
        test_bypass();
        test_timeout();
        test_backpressure();
        test_back_to_back(8'd13, 8'd11, 8'd200, 8'd3);
        test_back_to_back(8'd0, 8'd44, 8'd9, 8'd9);
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
